vram_wr_sink: RTL
=================

Name: vram_wr_sink

Overview:
- FPGA-side receiver of the HPS-to-FPGA VRAM write interface (address, write-enable, 64-bit data, byte-enables, busy flag, write IRQ).
- Buffers CPU VRAM writes in an in-order FIFO and commits them to the PPU VRAM write port only while the PPU reports vertical blank.
- Drives backpressure (cpu_wr_busy) and a per-frame "vblank started" IRQ back to the HPS.

Parameters:
- ADDR_W, 13, VRAM word address width
- DATA_W, 64, VRAM data width
- BE_W, 8, byte-enable width (DATA_W/8)
- FIFO_DEPTH, 16, write-buffer entries; power of 2, ≥4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- h2f_wraddr  in  ADDR_W  CPU write address
- h2f_wren  in  1  CPU write strobe, one write per cycle high
- h2f_wrdata  in  DATA_W  CPU write data
- h2f_byteena  in  BE_W  CPU byte enables
- vblank  in  1  PPU vertical-blank level, synchronous to clk
- ovf_clr  in  1  clears wr_overflow
- vram_wraddr  out  ADDR_W  VRAM write address
- vram_wren  out  1  VRAM write strobe
- vram_wrdata  out  DATA_W  VRAM write data
- vram_byteena  out  BE_W  VRAM byte enables
- cpu_wr_busy  out  1  backpressure to CPU
- cpu_vram_wr_irq  out  1  one-cycle pulse at vblank start
- wr_overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset: all outputs 0, FIFO emptied, state IDLE. Reset asserted mid-drain discards all buffered entries.
- Push: on h2f_wren=1 with h2f_byteena≠0 and FIFO not full, push {addr,data,be}.
  - h2f_byteena=0: write ignored, nothing pushed, no overflow.
  - h2f_wren=1 while full: write dropped; wr_overflow=1 on the next cycle.
- wr_overflow stays set until ovf_clr=1. If ovf_clr and a new drop occur in the same cycle, set wins.
- Occupancy counter is DEPTH-wide+1. cpu_wr_busy=1 iff count ≥ FIFO_DEPTH-1 (registered count).
- Simultaneous push and pop leaves count unchanged.
- No bypass: an entry pushed in cycle N is first poppable at the edge ending cycle N+1.
- State machine, evaluated at each clk edge on the sampled vblank:
  - IDLE: vblank=1 and FIFO non-empty → DRAIN; vblank=1 and FIFO empty → DONE.
  - DRAIN: vblank=0 → IDLE. While vblank=1, one pop per edge. FIFO empties with vblank=1 → DONE.
  - DONE: vblank=0 → IDLE. vblank=1 and FIFO non-empty (written during vblank) → DRAIN.
- Drain timing: on each edge where vblank=1 and the FIFO is non-empty (IDLE, DRAIN or DONE), head is popped into the vram_* output registers with vram_wren=1 for that cycle. Otherwise vram_wren=0 and addr/data/be hold their last values.
- First vram_wren appears the cycle after vblank is first sampled high. Throughput is 1 write/cycle.
- vblank falling mid-drain: no vram_wren in the cycle after vblank is sampled low. Remaining entries are kept for the next vblank, order preserved.
- Ordering is strictly FIFO. Duplicate addresses are all written, last one wins in VRAM.
- cpu_vram_wr_irq: registered pulse, high for exactly one cycle after the edge where vblank is sampled 1 and the previous sample was 0. Pulses every frame regardless of FIFO state.

Optional Feature:
- Macro VRAM_WR_DROP_CNT_EN.
- When defined: extra output drop_cnt [15:0]. It increments once per dropped write, saturates at 16'hFFFF, resets to 0, and is cleared by ovf_clr (a drop in the same cycle wins, leaving 1).
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle with 5 entries buffered → all outputs 0 immediately. After release, raising vblank produces no vram_wren.
- Write addr 0x010/0x011/0x012 (data 0xA..0xC, be 0xFF) with vblank=0 → no vram_wren. Raise vblank → irq pulses 1 cycle, vram_wren high 3 consecutive cycles with addr 0x010,0x011,0x012 in order, then DONE.
- Write 15 entries → cpu_wr_busy=1 after the 15th. 16th accepted; 17th dropped → wr_overflow=1, drop_cnt=1 (if enabled). ovf_clr → both 0.
- Buffer 5 entries, vblank high for 2 sampled cycles → exactly 2 VRAM writes. Next vblank → remaining 3 written in order.
- Write with h2f_byteena=0 → count unchanged, no VRAM write, no overflow. be=0x0F passes through unchanged.
- CPU writes addr 0x1FFF while in DONE with vblank=1 → vram_wren for 0x1FFF two cycles after the CPU write.

Source files
------------

// File: rtl/vram_wr_sink.sv
// vram_wr_sink: buffers CPU VRAM writes in a FIFO and commits them to the PPU only during vblank.
// Optional feature: define VRAM_WR_DROP_CNT_EN to add a saturating 16-bit dropped-write counter (drop_cnt).
module vram_wr_sink #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int BE_W       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] h2f_wraddr,
  input  logic              h2f_wren,
  input  logic [DATA_W-1:0] h2f_wrdata,
  input  logic [BE_W-1:0]   h2f_byteena,
  input  logic              vblank,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] vram_wraddr,
  output logic              vram_wren,
  output logic [DATA_W-1:0] vram_wrdata,
  output logic [BE_W-1:0]   vram_byteena,
  output logic              cpu_wr_busy,
  output logic              cpu_vram_wr_irq,
  output logic              wr_overflow
`ifdef VRAM_WR_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ADDR_W + DATA_W + BE_W;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d, head_addr;
  logic [DATA_W-1:0] data_q, data_d, head_data;
  logic [BE_W-1:0]   be_q, be_d, head_be;
  logic              wren_q, wren_d, irq_q, irq_d, vb_prev_q, vb_prev_d, ovf_q, ovf_d;
  logic              req, full, push, pop, drop;
`ifdef VRAM_WR_DROP_CNT_EN
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif
  // Full/empty decisions use the registered count, so a fresh entry is never popped in its push cycle.
  assign req  = h2f_wren && (h2f_byteena != '0);
  assign full = count_q == CW'(FIFO_DEPTH);
  assign push = req && !full;
  assign drop = req && full;
  assign pop  = vblank && (count_q != '0);
  assign {head_addr, head_data, head_be} = mem_q[rd_ptr_q];
  // Next-state for pointers, occupancy, VRAM port, IRQ edge detect, overflow and drain FSM.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    wren_d    = pop;
    addr_d    = pop ? head_addr : addr_q;
    data_d    = pop ? head_data : data_q;
    be_d      = pop ? head_be : be_q;
    irq_d     = vblank && !vb_prev_q;
    vb_prev_d = vblank;
    ovf_d     = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    state_d   = !vblank ? IDLE :
                (state_q == DRAIN) ? ((count_d == '0) ? DONE : DRAIN) :
                ((count_q != '0) ? DRAIN : DONE);
  end
`ifdef VRAM_WR_DROP_CNT_EN
  // Dropped-write counter: saturates, cleared by ovf_clr unless a drop lands in the same cycle.
  always_comb begin
    drop_cnt_d = drop ? (ovf_clr ? 16'd1 : (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1) :
                 ovf_clr ? 16'd0 : drop_cnt_q;
  end
  // Dropped-write counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
  // Write-buffer storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {h2f_wraddr, h2f_wrdata, h2f_byteena};
  end
  // Control and output registers; reset discards all buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      irq_q     <= 1'b0;
      vb_prev_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      irq_q     <= irq_d;
      vb_prev_q <= vb_prev_d;
      ovf_q     <= ovf_d;
    end
  end
  assign vram_wraddr     = addr_q;
  assign vram_wren       = wren_q;
  assign vram_wrdata     = data_q;
  assign vram_byteena    = be_q;
  assign cpu_wr_busy     = count_q >= CW'(FIFO_DEPTH - 1);
  assign cpu_vram_wr_irq = irq_q;
  assign wr_overflow     = ovf_q;
endmodule
